// File: rtl/score_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// score_accumulator_pkg
// Shared definitions for the score accumulator: FSM state encoding, channel
// count / channel index width and the default datapath widths.
// -----------------------------------------------------------------------------
package score_accumulator_pkg;

    // Number of scored channels and width of the incoming channel index.
    localparam int N_CH = 5;
    localparam int CH_W = 3;

    // Default datapath sizing.
    localparam int DEF_IN_W      = 16;
    localparam int DEF_ACC_W     = 32;
    localparam int DEF_FRAME_LEN = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

endpackage

// File: rtl/score_accumulator_sat_adder.sv
// -----------------------------------------------------------------------------
// sat_adder
// Unsigned saturating adder: o_sum = min(i_a + zext(i_b), 2^ACC_W - 1).
// Ports:
//   i_a    [ACC_W-1:0]  current accumulator value
//   i_b    [IN_W-1:0]   sample to add (zero-extended)
//   o_sum  [ACC_W-1:0]  clamped sum
//   o_ovf               high when the true sum exceeded the ACC_W range
// Assumes IN_W <= ACC_W.
// -----------------------------------------------------------------------------
module sat_adder #(
    parameter int ACC_W = 32,
    parameter int IN_W  = 16
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [IN_W-1:0]  i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    // One extra bit catches the carry out of the ACC_W-bit addition.
    logic [ACC_W:0] w_wide;

    assign w_wide = {1'b0, i_a} + (ACC_W + 1)'(i_b);
    assign o_ovf  = w_wide[ACC_W];
    assign o_sum  = o_ovf ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];

endmodule

// File: rtl/score_accumulator.sv
// -----------------------------------------------------------------------------
// score_accumulator
// Accumulates an unsigned per-channel score over a frame of FRAME_LEN accepted
// (channel, sample) beats, then publishes the five totals on x1..x5 with a
// one-cycle frame_valid strobe. Published values hold until the next publish.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               begin a frame (only honoured in IDLE)
//   abort               cancel the current frame, no publish
//   in_valid/in_ready   beat handshake; in_ready depends on state only
//   in_ch, in_data      channel index (0..4 valid) and sample
//   x1..x5              published totals for channels 0..4
//   frame_valid         strobe: x outputs are new this cycle
//   busy                high in ACCUM or PUBLISH
//   sat                 per-channel saturation flags of the last published frame
//   bad_ch              last published frame carried a channel index >= 5
// -----------------------------------------------------------------------------
module score_accumulator
    import score_accumulator_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [IN_W-1:0]   in_data,
    output logic [ACC_W-1:0]  x1,
    output logic [ACC_W-1:0]  x2,
    output logic [ACC_W-1:0]  x3,
    output logic [ACC_W-1:0]  x4,
    output logic [ACC_W-1:0]  x5,
    output logic              frame_valid,
    output logic              busy,
    output logic [N_CH-1:0]   sat,
    output logic              bad_ch
);

    localparam int CNT_W = $clog2(FRAME_LEN);

    state_t r_state;
    state_t w_state_next;

    // Working (in-frame) state.
    logic [ACC_W-1:0] r_acc [N_CH];
    logic [N_CH-1:0]  r_sat_work;
    logic             r_bad_work;
    logic [CNT_W-1:0] r_cnt;

    // Published state.
    logic [ACC_W-1:0] r_x [N_CH];
    logic [N_CH-1:0]  r_sat;
    logic             r_bad;
    logic             r_frame_valid;

    logic             w_accept;
    logic             w_last;
    logic             w_ch_ok;
    logic [N_CH-1:0]  w_hit;
    logic [ACC_W-1:0] w_acc_sel;
    logic [ACC_W-1:0] w_sum;
    logic             w_ovf;

    // ------------------------------------------------------------------
    // Handshake and beat bookkeeping
    // ------------------------------------------------------------------
    assign w_accept = in_valid && (r_state == ST_ACCUM);
    assign w_last   = w_accept && (r_cnt == CNT_W'(FRAME_LEN - 1));
    assign w_ch_ok  = (in_ch < CH_W'(N_CH));

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_hit
            assign w_hit[gi] = w_accept && (in_ch == CH_W'(gi));
        end
    endgenerate

    // Select the addressed accumulator; one shared adder serves all channels.
    always_comb begin
        w_acc_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (in_ch == CH_W'(i)) begin
                w_acc_sel = r_acc[i];
            end
        end
    end

    sat_adder #(
        .ACC_W (ACC_W),
        .IN_W  (IN_W)
    ) u_sat_adder (
        .i_a   (w_acc_sel),
        .i_b   (in_data),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // abort wins over start while idle
                if (start && !abort) begin
                    w_state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // abort wins over a simultaneously accepted final beat
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_last) begin
                    w_state_next = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_acc[i] <= '0;
                r_x[i]   <= '0;
            end
            r_sat_work    <= '0;
            r_bad_work    <= 1'b0;
            r_cnt         <= '0;
            r_sat         <= '0;
            r_bad         <= 1'b0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        for (int i = 0; i < N_CH; i++) begin
                            r_acc[i] <= '0;
                        end
                        r_sat_work <= '0;
                        r_bad_work <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept && !abort) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_ch_ok) begin
                            for (int i = 0; i < N_CH; i++) begin
                                if (w_hit[i]) begin
                                    r_acc[i]      <= w_sum;
                                    // sticky: once clamped, the flag stays set
                                    r_sat_work[i] <= r_sat_work[i] | w_ovf;
                                end
                            end
                        end else begin
                            // out-of-range channel: drop data, still counts
                            r_bad_work <= 1'b1;
                        end
                    end
                end
                ST_PUBLISH: begin
                    if (!abort) begin
                        for (int i = 0; i < N_CH; i++) begin
                            r_x[i] <= r_acc[i];
                        end
                        r_sat         <= r_sat_work;
                        r_bad         <= r_bad_work;
                        r_frame_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = (r_state == ST_ACCUM);
    assign busy        = (r_state == ST_ACCUM) || (r_state == ST_PUBLISH);
    assign x1          = r_x[0];
    assign x2          = r_x[1];
    assign x3          = r_x[2];
    assign x4          = r_x[3];
    assign x5          = r_x[4];
    assign sat         = r_sat;
    assign bad_ch      = r_bad;
    assign frame_valid = r_frame_valid;

endmodule
